// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models mult/div latency.
// Results are computed at the start edge and committed after the busy window.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MDUstart,
    output logic        E_MDUbusy,
    output logic [31:0] E_MDUout,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return 32'd0 - v;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_we;

    logic             w_start;
    logic signed [63:0] w_smul;
    logic [63:0]      w_umul;
    logic [31:0]      w_dvd;
    logic [31:0]      w_dvs;
    logic [31:0]      w_q;
    logic [31:0]      w_r;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_res_we;
    logic [CNT_W-1:0] w_load;
    logic [31:0]      w_out;

    // Operation decode and full-result arithmetic for the start edge.
    // Signed division runs on magnitudes so INT_MIN / -1 needs no special case.
    always_comb begin
        w_start  = (E_MDUop >= OP_MULT) && (E_MDUop <= OP_DIVU);
        w_smul   = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
        w_umul   = {32'd0, E_A} * {32'd0, E_B};
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b0;
        w_load   = CNT_ZERO;
        if ((E_MDUop == OP_DIV) && E_A[31]) begin
            w_dvd = neg32(E_A);
        end else begin
            w_dvd = E_A;
        end
        if (E_B == 32'd0) begin
            w_dvs = 32'd1;
        end else if ((E_MDUop == OP_DIV) && E_B[31]) begin
            w_dvs = neg32(E_B);
        end else begin
            w_dvs = E_B;
        end
        w_q = w_dvd / w_dvs;
        w_r = w_dvd % w_dvs;
        case (E_MDUop)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
                w_res_we = 1'b1;
                w_load   = MULT_LOAD;
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
                w_res_we = 1'b1;
                w_load   = MULT_LOAD;
            end
            OP_DIV: begin
                w_res_lo = (E_A[31] ^ E_B[31]) ? neg32(w_q) : w_q;
                w_res_hi = E_A[31] ? neg32(w_r) : w_r;
                w_res_we = (E_B != 32'd0);
                w_load   = DIV_LOAD;
            end
            OP_DIVU: begin
                w_res_lo = w_q;
                w_res_hi = w_r;
                w_res_we = (E_B != 32'd0);
                w_load   = DIV_LOAD;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
                w_res_we = 1'b0;
                w_load   = CNT_ZERO;
            end
        endcase
    end

    // HI/LO read mux for mfhi/mflo.
    always_comb begin
        case (E_MDUop)
            OP_MFHI: w_out = r_hi;
            OP_MFLO: w_out = r_lo;
            default: w_out = 32'd0;
        endcase
    end

    // Idle/run sequencer: accepts ops in idle, commits pending result on the last busy edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_we <= w_res_we;
                        r_cnt     <= w_load;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else if (E_MDUop == OP_MTHI) begin
                        r_hi <= E_A;
                    end else if (E_MDUop == OP_MTLO) begin
                        r_lo <= E_A;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_ONE) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end else begin
                            r_pend_we <= 1'b0;
                        end
                        r_pend_we <= 1'b0;
                        r_cnt     <= CNT_ZERO;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign E_MDUstart = w_start;
    assign E_MDUbusy  = r_busy;
    assign E_MDUout   = w_out;
    assign E_HI       = r_hi;
    assign E_LO       = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO pushed at issue, popped when busy drops.
module tb_e_mdu;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MDUstart;
    logic        E_MDUbusy;
    logic [31:0] E_MDUout;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int          checks;
    int          errors;
    res_t        sb[$];
    logic [3:0]  busy_op;
    logic [31:0] busy_a;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mdu dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUop    (E_MDUop),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_MDUstart (E_MDUstart),
        .E_MDUbusy  (E_MDUbusy),
        .E_MDUout   (E_MDUout),
        .E_HI       (E_HI),
        .E_LO       (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents the op for one edge, returns at the following negedge.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_start);
        E_MDUop = op;
        E_A     = a;
        E_B     = b;
        #1;
        chk({tag, "_start"}, {31'd0, E_MDUstart}, {31'd0, exp_start});
        @(posedge clk);
        @(negedge clk);
        E_MDUop = 4'd0;
    endtask

    task automatic wait_busy(input string tag, input int exp_n);
        int n;
        n = 0;
        while ((E_MDUbusy === 1'b1) && (n < 100)) begin
            n++;
            E_MDUop = busy_op;
            E_A     = busy_a;
            @(negedge clk);
        end
        E_MDUop = 4'd0;
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    endtask

    task automatic complete(input string tag);
        res_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed_hi=%h observed_lo=%h", tag, E_HI, E_LO);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, E_HI, e.hi);
            chk({tag, "_lo"}, E_LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic read(input string tag, input logic [3:0] op, input logic [31:0] exp);
        E_MDUop = op;
        #1;
        chk(tag, E_MDUout, exp);
        E_MDUop = 4'd0;
    endtask

    initial begin
        int seen_busy;
        checks  = 0;
        errors  = 0;
        busy_op = 4'd0;
        busy_a  = 32'd0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        reset   = 1'b0;
        E_MDUop = 4'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, E_MDUbusy}, 32'd0);
        chk("rst_hi", E_HI, 32'd0);
        chk("rst_lo", E_LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // signed mult
        sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFE});
        issue("mult", 4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        wait_busy("mult", 5);
        complete("mult");
        read("mult_mfhi", 4'd5, 32'hFFFFFFFF);
        read("mult_mflo", 4'd6, 32'hFFFFFFFE);

        // unsigned mult
        sb.push_back('{hi: 32'h00000001, lo: 32'hFFFFFFFE});
        issue("multu", 4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        wait_busy("multu", 5);
        complete("multu");

        // signed divide with negative dividend
        sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
        issue("div_neg", 4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1);
        wait_busy("div_neg", 10);
        complete("div_neg");

        // overflow case
        sb.push_back('{hi: 32'h00000000, lo: 32'h80000000});
        issue("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_busy("div_ovf", 10);
        complete("div_ovf");

        // mthi then visible on mfhi next cycle
        issue("mthi", 4'd7, 32'h12345678, 32'd0, 1'b0);
        chk("mthi_busy", {31'd0, E_MDUbusy}, 32'd0);
        read("mthi_mfhi", 4'd5, 32'h12345678);
        m_hi = 32'h12345678;

        // divu by zero with an mtlo presented throughout busy
        sb.push_back('{hi: m_hi, lo: m_lo});
        busy_op = 4'd8;
        busy_a  = 32'hAAAA0000;
        issue("divu_zero", 4'd4, 32'h00000007, 32'h00000000, 1'b1);
        wait_busy("divu_zero", 10);
        busy_op = 4'd0;
        busy_a  = 32'd0;
        complete("divu_zero");
        read("divu_zero_mflo", 4'd6, 32'h80000000);

        // unused opcode has no effect
        issue("op9", 4'd9, 32'hDEADBEEF, 32'h1, 1'b0);
        chk("op9_busy", {31'd0, E_MDUbusy}, 32'd0);
        chk("op9_hi", E_HI, m_hi);
        chk("op9_lo", E_LO, m_lo);

        // reset mid-run: third busy cycle, between edges
        issue("rst_mult", 4'd1, 32'h00000003, 32'h00000004, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, E_MDUbusy}, 32'd0);
        chk("rst_mid_hi", E_HI, 32'd0);
        chk("rst_mid_lo", E_LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (E_MDUbusy !== 1'b0) seen_busy++;
        end
        chk("rst_after_busy", 32'(seen_busy), 32'd0);
        chk("rst_after_lo", E_LO, 32'd0);

        // back-to-back: div on the edge right after the mult busy falls
        sb.push_back('{hi: 32'h00000001, lo: 32'h00000000});
        sb.push_back('{hi: 32'h00000002, lo: 32'h0000000E});
        issue("b2b_mult", 4'd1, 32'h00010000, 32'h00010000, 1'b1);
        wait_busy("b2b_mult", 5);
        complete("b2b_mult");
        issue("b2b_div", 4'd3, 32'd100, 32'd7, 1'b1);
        wait_busy("b2b_div", 10);
        complete("b2b_div");
        read("b2b_mfhi", 4'd5, 32'h00000002);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits directly downstream of the D/E pipeline register.
- Consumes the E-stage forwarded operands and an MDU opcode decoded from E_Instr.
- Owns the architectural HI/LO registers and models the multi-cycle latency of mult/div.
- Reports busy/start to the hazard unit, which stalls D on any MDU instruction while this unit is occupied.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range ≥1)
DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range ≥1)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately when low
E_MDUop  input  4  0=none 1=mult 2=multu 3=div 4=divu 5=mfhi 6=mflo 7=mthi 8=mtlo, 9-15=none
E_A  input  32  forwarded rs value (multiplicand/dividend/mthi/mtlo source)
E_B  input  32  forwarded rt value (multiplier/divisor)
E_MDUstart  output  1  combinational: E_MDUop is 1..4
E_MDUbusy  output  1  registered: operation in flight
E_MDUout  output  32  combinational: HI for mfhi, LO for mflo, else 0
E_HI  output  32  current HI register
E_LO  output  32  current LO register

Behaviour:
- Reset (reset low, asynchronous): HI=0, LO=0, busy=0, internal counter=0, pending result cleared. Takes effect regardless of operation in progress. Any in-flight mult/div is discarded and HI/LO do not update from it. After release, the first edge behaves as idle.
- State: IDLE (busy=0) / RUN (busy=1, counter>0).
- IDLE + start op (1..4) at edge:
  - Latch E_A, E_B and op. Compute the full result into pending HI/LO.
  - Counter loads MULT_CYCLES or DIV_CYCLES. busy=1 from the next cycle.
- RUN, each edge: counter decrements. On the edge where counter==1: HI/LO take the pending values, busy=0, counter=0.
- busy is therefore high for exactly N cycles after the start edge. The new HI/LO are visible on E_HI/E_LO/E_MDUout in the cycle after busy falls.
- mthi/mtlo in IDLE: HI (or LO) <= E_A at the edge, no busy. The write is visible on E_MDUout the next cycle.
- mfhi/mflo: purely combinational read of the current HI/LO. No state change.
- Any op 1..8 presented while busy=1: ignored, no state change. The hazard unit prevents this case, but RTL must still tolerate it.
- E_MDUstart is combinational from E_MDUop only, independent of busy. It lets the hazard unit stall in the start cycle itself.
- A flushed or bubbled E-stage (op=0) has no effect.
- Arithmetic:
  - mult: signed 32×32 → 64; HI=[63:32], LO=[31:0].
  - multu: the same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): unit still goes busy for DIV_CYCLES; HI/LO remain unchanged at completion.
- Hazard contract: the hazard unit stalls D and holds DE_en low while a D-stage MDU instruction meets (E_MDUstart | E_MDUbusy). This block does not drive stall itself.

Test Plan:
- mult E_A=0xFFFFFFFF E_B=0x00000002 → E_MDUstart=1 that cycle; busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi next cycle gives E_MDUout=0xFFFFFFFF.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div E_A=0xFFFFFFF9 (-7) E_B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x12345678 then divu 7/0 → busy 10 cycles; HI stays 0x12345678, LO unchanged. mtlo 0xAAAA0000 issued while busy is ignored; LO does not change.
- mult started, then reset driven low mid-RUN (3rd busy cycle, asynchronously between edges) → busy, HI and LO go 0 immediately. After release no completion occurs, and busy stays 0.
- Back-to-back: mult completes, and div is presented on the edge right after busy falls → accepted; busy high 10 more cycles. Final HI/LO hold the div result, and the mult result was visible in between.
